// File: rtl/led_event_blinker.sv
// led_event_blinker: turns single-cycle event pulses into visible LED blinks.
// Each accepted event gives one ON interval followed by one OFF gap. Events
// that arrive during a blink are queued in a saturating pending counter and
// replayed back-to-back. An event dropped at saturation raises overflow for
// one cycle.
module led_event_blinker #(
  parameter logic [31:0] ON_COUNT  = 32'd5_000_000,
  parameter logic [31:0] OFF_COUNT = 32'd5_000_000,
  parameter int unsigned PEND_W    = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              event_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  state_t              state_r;
  logic [31:0]         cnt_r;

  logic                last_on_s;
  logic                last_off_s;
  logic                pend_nz_s;
  logic                pend_full_s;
  logic                inc_s;
  logic                dec_s;
  logic [PEND_W-1:0]   pend_nxt_s;
  logic                ovf_nxt_s;

  // Phase-end detection and the queue increment/decrement terms.
  always_comb begin
    last_on_s   = (state_r == ST_ON)  && (cnt_r == (ON_COUNT  - 32'd1));
    last_off_s  = (state_r == ST_OFF) && (cnt_r == (OFF_COUNT - 32'd1));
    pend_nz_s   = (pending != PEND_ZERO);
    pend_full_s = (pending == PEND_MAX);
    dec_s       = last_off_s && pend_nz_s;
    // An event on the last OFF cycle with nothing queued starts the next
    // blink directly, so it is not counted into the queue.
    inc_s       = event_in && !(last_off_s && !pend_nz_s);
  end

  // Next pending count and overflow pulse.
  always_comb begin
    pend_nxt_s = pending;
    ovf_nxt_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      pend_nxt_s = PEND_ZERO;
    end else if (inc_s && !dec_s) begin
      if (pend_full_s) begin
        ovf_nxt_s = 1'b1;
      end else begin
        pend_nxt_s = pending + PEND_ONE;
      end
    end else if (dec_s && !inc_s) begin
      pend_nxt_s = pending - PEND_ONE;
    end else begin
      // Neither, or both: a new event takes the slot of the consumed one.
      pend_nxt_s = pending;
    end
  end

  // Blink FSM with phase counter; all outputs registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 32'd0;
      led_out  <= 1'b0;
      busy     <= 1'b0;
      pending  <= PEND_ZERO;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_nxt_s;
      overflow <= ovf_nxt_s;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 32'd0;
          if (event_in) begin
            state_r <= ST_ON;
            led_out <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            led_out <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_ON: begin
          busy <= 1'b1;
          if (last_on_s) begin
            state_r <= ST_OFF;
            cnt_r   <= 32'd0;
            led_out <= 1'b0;
          end else begin
            state_r <= ST_ON;
            cnt_r   <= cnt_r + 32'd1;
            led_out <= 1'b1;
          end
        end
        ST_OFF: begin
          if (last_off_s) begin
            cnt_r <= 32'd0;
            if (pend_nz_s || event_in) begin
              state_r <= ST_ON;
              led_out <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              led_out <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            state_r <= ST_OFF;
            cnt_r   <= cnt_r + 32'd1;
            led_out <= 1'b0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 32'd0;
          led_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed bench for led_event_blinker. dut0 uses ON=4/OFF=3/PEND_W=2,
// dut1 uses ON=1/OFF=1/PEND_W=2. Expected waveforms are hand-written as
// cycle ranges; window bit k holds the expected value in cycle k.
module tb_led_event_blinker;

  logic       clk;
  logic       nrst;
  logic       ev0;
  logic       ev1;
  logic       led0;
  logic       led1;
  logic       busy0;
  logic       busy1;
  logic [1:0] pend0;
  logic [1:0] pend1;
  logic       ovf0;
  logic       ovf1;

  int n_pass;
  int n_total;

  led_event_blinker #(
    .ON_COUNT (32'd4),
    .OFF_COUNT(32'd3),
    .PEND_W   (2)
  ) dut0 (
    .clk     (clk),
    .nrst    (nrst),
    .event_in(ev0),
    .led_out (led0),
    .busy    (busy0),
    .pending (pend0),
    .overflow(ovf0)
  );

  led_event_blinker #(
    .ON_COUNT (32'd1),
    .OFF_COUNT(32'd1),
    .PEND_W   (2)
  ) dut1 (
    .clk     (clk),
    .nrst    (nrst),
    .event_in(ev1),
    .led_out (led1),
    .busy    (busy1),
    .pending (pend1),
    .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] rng(input int lo, input int hi);
    logic [47:0] r;
    r = 48'd0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [3:0] got, input logic [3:0] exp);
    n_total = n_total + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Drive window ev bit c in cycle c, then check outputs of cycle c+1.
  task automatic run_win(input string tag, input bit sel, input logic [47:0] ev,
                         input logic [47:0] led, input logic [47:0] bsy,
                         input logic [47:0] p1, input logic [47:0] p2,
                         input logic [47:0] p3, input logic [47:0] ovf);
    logic [3:0] exp_p;
    for (int c = 0; c < 47; c++) begin
      if (sel) ev1 = ev[c];
      else     ev0 = ev[c];
      @(posedge clk);
      #1;
      exp_p = p3[c+1] ? 4'd3 : (p2[c+1] ? 4'd2 : (p1[c+1] ? 4'd1 : 4'd0));
      chk({tag, ".led"},  c + 1, {3'b000, sel ? led1 : led0},   {3'b000, led[c+1]});
      chk({tag, ".busy"}, c + 1, {3'b000, sel ? busy1 : busy0}, {3'b000, bsy[c+1]});
      chk({tag, ".pend"}, c + 1, {2'b00, sel ? pend1 : pend0},  exp_p);
      chk({tag, ".ovf"},  c + 1, {3'b000, sel ? ovf1 : ovf0},   {3'b000, ovf[c+1]});
    end
    ev0 = 1'b0;
    ev1 = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nrst    = 1'b0;
    ev0     = 1'b0;
    ev1     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.led0",  0, {3'b000, led0},  4'd0);
    chk("rst.busy0", 0, {3'b000, busy0}, 4'd0);
    chk("rst.pend0", 0, {2'b00, pend0},  4'd0);
    chk("rst.ovf0",  0, {3'b000, ovf0},  4'd0);
    chk("rst.led1",  0, {3'b000, led1},  4'd0);
    chk("rst.busy1", 0, {3'b000, busy1}, 4'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Single pulse at 10
    run_win("single", 1'b0, rng(10, 10), rng(11, 14), rng(11, 17),
            48'd0, 48'd0, 48'd0, 48'd0);

    // Pulses at 10, 12, 13: three contiguous blinks
    run_win("queue", 1'b0, rng(10, 10) | rng(12, 13),
            rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31),
            rng(13, 13) | rng(18, 24), rng(14, 17), 48'd0, 48'd0);

    // event_in held 10..16: saturation, events at 14,15,16 dropped
    run_win("sat", 1'b0, rng(10, 16),
            rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35), rng(11, 38),
            rng(12, 12) | rng(25, 31), rng(13, 13) | rng(18, 24), rng(14, 17),
            rng(15, 17));

    // Event on the last OFF cycle with nothing queued
    run_win("lastoff", 1'b0, rng(10, 10) | rng(17, 17),
            rng(11, 14) | rng(18, 21), rng(11, 24),
            48'd0, 48'd0, 48'd0, 48'd0);

    // Minimal phases on dut1, event held 3 cycles
    run_win("short", 1'b1, rng(10, 12),
            rng(11, 11) | rng(13, 13) | rng(15, 15), rng(11, 16),
            rng(12, 14), 48'd0, 48'd0, 48'd0);

    // Reset mid-ON with pending=2
    for (int c = 0; c < 13; c++) begin
      ev0 = (c >= 10 && c <= 12) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    ev0 = 1'b0;
    chk("pre_rst.led",  13, {3'b000, led0}, 4'd1);
    chk("pre_rst.pend", 13, {2'b00, pend0}, 4'd2);
    nrst = 1'b0;
    #1;
    chk("async_rst.led",  13, {3'b000, led0},  4'd0);
    chk("async_rst.busy", 13, {3'b000, busy0}, 4'd0);
    chk("async_rst.pend", 13, {2'b00, pend0},  4'd0);
    chk("async_rst.ovf",  13, {3'b000, ovf0},  4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst.led",  c, {3'b000, led0},  4'd0);
      chk("post_rst.busy", c, {3'b000, busy0}, 4'd0);
      chk("post_rst.pend", c, {2'b00, pend0},  4'd0);
    end
    ev0 = 1'b1;
    @(posedge clk);
    #1;
    ev0 = 1'b0;
    chk("post_rst_evt.led",  0, {3'b000, led0},  4'd1);
    chk("post_rst_evt.busy", 0, {3'b000, busy0}, 4'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_evt.idle", 0, {3'b000, busy0}, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
